// File: rtl/radar_ram_pkg.sv
// Shared definitions for the radar dual-port sample RAM (2048 x 8) and its writer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package radar_ram_pkg;

  localparam int RAM_ADDR_W = 11;
  localparam int RAM_DATA_W = 8;

  // Writer FSM: IDLE waits for start, EVEN expects the first sample of a pair,
  // ODD expects the second sample and issues the pair write.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/ram_frame_writer.sv
// Packs a sample stream into pair writes to the dual-port RAM (even addr on A, odd on B).
// Latency: pair write (wr_en_a/b) one cycle after the odd sample transfer; start -> in_ready next cycle.
// Backpressure: in_ready low in IDLE; in_valid low stalls indefinitely, a held even sample is kept.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   one-cycle frame capture request, honoured only in IDLE
//   in_valid/in_data/in_ready  sample stream, transfer on in_valid & in_ready
//   wr_en_a/wr_addr_a/wr_data_a  port A write (even address, earlier sample)
//   wr_en_b/wr_addr_b/wr_data_b  port B write (wr_addr_a + 1, later sample)
//   busy                    high from the accepted start until frame_done
//   frame_done              one-cycle pulse with the final pair write
//   bank                    bank of the frame last completed
//
// Optional feature macro: RAM_WRITER_BANK_EN (ping-pong banking on the address MSB).
// Without it the whole RAM is one frame and bank is tied to 0.
module ram_frame_writer
  import radar_ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en_a,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [DATA_W-1:0] wr_data_a,
  output logic              wr_en_b,
  output logic [ADDR_W-1:0] wr_addr_b,
  output logic [DATA_W-1:0] wr_data_b,
  output logic              busy,
  output logic              frame_done,
  output logic              bank
);

  localparam int PAIR_W = ADDR_W - 1;

`ifdef RAM_WRITER_BANK_EN
  // Half the RAM per frame: pair index spans ADDR_W-2 bits.
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'((1 << (ADDR_W - 2)) - 1);
`else
  localparam logic [PAIR_W-1:0] LAST_PAIR = '1;
`endif

  wr_state_e         state_q;
  wr_state_e         state_d;
  logic [PAIR_W-1:0] pair_q;
  logic [DATA_W-1:0] hold_q;
  logic              xfer;
  logic              pair_fire;
  logic              last_fire;
  logic [ADDR_W-1:0] pair_addr;

  // in_ready is a flop that mirrors (state != IDLE), so it is safe to use here.
  assign xfer = in_valid & in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = EVEN;
      EVEN: if (xfer)  state_d = ODD;
      ODD:  if (xfer)  state_d = (pair_q == LAST_PAIR) ? IDLE : EVEN;
      default:         state_d = IDLE;
    endcase
  end

  // Output decode: a pair write fires on the odd-sample transfer.
  always_comb begin
    pair_fire = 1'b0;
    last_fire = 1'b0;
    if (state_q == ODD && xfer) begin
      pair_fire = 1'b1;
      last_fire = (pair_q == LAST_PAIR);
    end
  end

`ifdef RAM_WRITER_BANK_EN
  logic wbank_q;

  // pair_q MSB is always 0 while writing in banked mode, so OR-ing the bank in is exact.
  assign pair_addr = {pair_q, 1'b0} | {wbank_q, {(ADDR_W-1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank_q <= 1'b0;
      bank    <= 1'b0;
    end else if (last_fire) begin
      bank    <= wbank_q;
      wbank_q <= ~wbank_q;
    end
  end
`else
  assign pair_addr = {pair_q, 1'b0};
  assign bank      = 1'b0;
`endif

  // Registered outputs, pair counter and even-sample hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      wr_en_a    <= 1'b0;
      wr_en_b    <= 1'b0;
      wr_addr_a  <= '0;
      wr_addr_b  <= '0;
      wr_data_a  <= '0;
      wr_data_b  <= '0;
      frame_done <= 1'b0;
      pair_q     <= '0;
      hold_q     <= '0;
    end else begin
      in_ready   <= (state_d != IDLE);
      busy       <= (state_d != IDLE);
      wr_en_a    <= pair_fire;
      wr_en_b    <= pair_fire;
      frame_done <= last_fire;
      if (state_q == IDLE && start) begin
        pair_q <= '0;
      end
      if (state_q == EVEN && xfer) begin
        hold_q <= in_data;
      end
      if (pair_fire) begin
        wr_addr_a <= pair_addr;
        wr_addr_b <= pair_addr | ADDR_W'(1);
        wr_data_a <= hold_q;
        wr_data_b <= in_data;
        pair_q    <= pair_q + PAIR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ram_frame_writer.sv
module tb_ram_frame_writer;
  import radar_ram_pkg::*;

  localparam int AW = RAM_ADDR_W;
  localparam int DW = RAM_DATA_W;
`ifdef RAM_WRITER_BANK_EN
  localparam int FRAME_LEN = 1 << (AW - 1);
  localparam bit BANKED    = 1'b1;
`else
  localparam int FRAME_LEN = 1 << AW;
  localparam bit BANKED    = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          wr_en_a;
  logic [AW-1:0] wr_addr_a;
  logic [DW-1:0] wr_data_a;
  logic          wr_en_b;
  logic [AW-1:0] wr_addr_b;
  logic [DW-1:0] wr_data_b;
  logic          busy;
  logic          frame_done;
  logic          bank;

  ram_frame_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en_a   (wr_en_a),
    .wr_addr_a (wr_addr_a),
    .wr_data_a (wr_data_a),
    .wr_en_b   (wr_en_b),
    .wr_addr_b (wr_addr_b),
    .wr_data_b (wr_data_b),
    .busy      (busy),
    .frame_done(frame_done),
    .bank      (bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr_a;
    logic [DW-1:0] da;
    logic [DW-1:0] db;
    bit            done;
    bit            bnk;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int done_exp = 0;

  // Stimulus-side frame position model
  int            idx;
  logic [DW-1:0] hold_m;
  bit            fbank;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every pair write
  always @(negedge clk) begin : monitor
    exp_t          e;
    logic [AW-1:0] ab;
    if (rst_n) begin
      chk("wr_en_a_eq_wr_en_b", {31'b0, wr_en_a}, {31'b0, wr_en_b});
      if (frame_done) begin
        done_seen++;
        chk("done_implies_write", {31'b0, wr_en_a}, 32'd1);
      end
      if (wr_en_a) begin
        if (q.size() == 0) begin
          chk("unexpected_write", q.size(), 32'd1);
        end else begin
          e  = q.pop_front();
          ab = e.addr_a + 1'b1;
          chk("wr_addr_a", {21'b0, wr_addr_a}, {21'b0, e.addr_a});
          chk("wr_addr_b", {21'b0, wr_addr_b}, {21'b0, ab});
          chk("wr_data_a", {24'b0, wr_data_a}, {24'b0, e.da});
          chk("wr_data_b", {24'b0, wr_data_b}, {24'b0, e.db});
          chk("frame_done", {31'b0, frame_done}, {31'b0, e.done});
          if (e.done) begin
            chk("bank_at_done", {31'b0, bank}, {31'b0, e.bnk});
            chk("busy_at_done", {31'b0, busy}, 32'd0);
            chk("in_ready_at_done", {31'b0, in_ready}, 32'd0);
          end
        end
      end
    end
  end

  task automatic reset_vals(input string tag);
    chk({tag, "_in_ready"},   {31'b0, in_ready},   32'd0);
    chk({tag, "_wr_en_a"},    {31'b0, wr_en_a},    32'd0);
    chk({tag, "_wr_en_b"},    {31'b0, wr_en_b},    32'd0);
    chk({tag, "_wr_addr_a"},  {21'b0, wr_addr_a},  32'd0);
    chk({tag, "_wr_addr_b"},  {21'b0, wr_addr_b},  32'd0);
    chk({tag, "_wr_data_a"},  {24'b0, wr_data_a},  32'd0);
    chk({tag, "_wr_data_b"},  {24'b0, wr_data_b},  32'd0);
    chk({tag, "_busy"},       {31'b0, busy},       32'd0);
    chk({tag, "_frame_done"}, {31'b0, frame_done}, 32'd0);
    chk({tag, "_bank"},       {31'b0, bank},       32'd0);
  endtask

  // Called at posedge+1; leaves the bench at posedge+4 of the first frame cycle.
  task automatic do_start(input bit expect_done);
    start = 1'b1;
    #3;
    if (expect_done) chk("start_in_done_cycle", {31'b0, frame_done}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    #3;
    chk("in_ready_after_start", {31'b0, in_ready}, 32'd1);
    chk("busy_after_start",     {31'b0, busy},     32'd1);
  endtask

  // Presents one sample until it transfers; pushes the expected pair on odd samples.
  task automatic send(input logic [DW-1:0] d, input bit with_start);
    bit   rdy;
    int   n;
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    start    = with_start;
    rdy      = 1'b0;
    n        = 0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    in_valid = 1'b0;
    if (!rdy) begin
      chk("send_timeout", n, 32'd0);
      return;
    end
    if (idx[0] == 1'b0) begin
      hold_m = d;
    end else begin
      e.addr_a = AW'((fbank ? FRAME_LEN : 0) + idx - 1);
      e.da     = hold_m;
      e.db     = d;
      e.done   = (idx == FRAME_LEN - 1);
      e.bnk    = fbank;
      q.push_back(e);
    end
    if (idx == FRAME_LEN - 1) begin
      done_exp++;
      if (BANKED) fbank = ~fbank;
      idx = 0;
    end else begin
      idx++;
    end
  endtask

  task automatic idle_rand();
    while ($urandom_range(0, 9) > 2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    idx      = 0;
    fbank    = 1'b0;
    hold_m   = '0;
    #1;
    reset_vals("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Continuous frame, sample value = index mod 256
    do_start(1'b0);
    for (int i = 0; i < FRAME_LEN; i++) send(DW'(i), 1'b0);

    // Back-to-back start in frame_done cycle; ~30% valid duty
    do_start(1'b1);
    for (int i = 0; i < FRAME_LEN; i++) begin
      idle_rand();
      send(DW'(i), 1'b0);
    end

    // start pulsed with sample 100 mid-frame must be ignored
    do_start(1'b1);
    for (int i = 0; i < FRAME_LEN; i++) send(DW'(i) ^ 8'hA5, (i == 100));
    repeat (3) begin @(posedge clk); #1; end

    // Reset after an odd number (7) of samples
    do_start(1'b0);
    for (int i = 0; i < 7; i++) send(DW'(8'h40 + i), 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    reset_vals("midrst");
    chk("midrst_queue_empty", q.size(), 32'd0);
    q.delete();
    idx   = 0;
    fbank = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(1'b0);
    send(8'h3C, 1'b0);
    send(8'hC3, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("post_rst_pair_written", q.size(), 32'd0);
    rst_n = 1'b0;
    #1;
    q.delete();
    idx   = 0;
    fbank = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // in_valid high in IDLE without start
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("idle_in_ready", {31'b0, in_ready}, 32'd0);
      chk("idle_busy",     {31'b0, busy},     32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    begin
      int n;
      n = 0;
      while (q.size() != 0 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("queue_drained", q.size(), 32'd0);
    chk("frame_done_count", done_seen, done_exp);
    chk("frame_done_total", done_seen, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_frame_writer.md
# ram_frame_writer

Write-side companion to the radar dual-port sample RAM (2048 × 8, two synchronous ports). Accepts a stream of 8-bit samples after a `start` command, packs each consecutive pair and writes it in a single cycle: even address on port A, odd address on port B. These are the addresses the dual-port read path consumes. Sits between the ADC/decimation stream and the RAM; signals frame completion to the FFT/read side.

## Interface
- `ADDR_W`, 11: RAM address width per port.
- `DATA_W`, 8: sample width.

- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to capture one frame. Honoured only in IDLE.
- `in_valid`  in  1  sample valid.
- `in_data`  in  DATA_W  sample.
- `in_ready`  out  1  writer accepts a sample this cycle. A transfer occurs when `in_valid & in_ready`.
- `wr_en_a`  out  1  port A write strobe.
- `wr_addr_a`  out  ADDR_W  port A address; always even.
- `wr_data_a`  out  DATA_W  port A data.
- `wr_en_b`  out  1  port B write strobe.
- `wr_addr_b`  out  ADDR_W  port B address; always `wr_addr_a + 1`.
- `wr_data_b`  out  DATA_W  port B data.
- `busy`  out  1  high from the accepted `start` until `frame_done`.
- `frame_done`  out  1  one-cycle pulse with the final pair write.
- `bank`  out  1  bank of the frame last completed.

## Operation
- FRAME_LEN is 2^ADDR_W samples, or 2^(ADDR_W-1) when banking is enabled. FRAME_LEN is always even.
- State machine with three states:
  - IDLE: `in_ready`=0. On `start`, go to EVEN, clear the pair counter, assert `busy`.
  - EVEN: `in_ready`=1. A transfer latches the sample into the hold register and moves to ODD.
  - ODD: `in_ready`=1. A transfer issues a write of the pair and increments the pair counter.
    - Returns to EVEN if more pairs remain.
    - Returns to IDLE after the last pair, pulsing `frame_done`.
- Pair counter width is ADDR_W-1 bits. Address for pair k: `wr_addr_a` = {bank bit if enabled, k, 0}, `wr_addr_b` = same with LSB 1.
- `wr_data_a` is the earlier (even) sample; `wr_data_b` is the later sample.
- `start` in EVEN or ODD is ignored. A frame is never restarted.
- `in_valid` low stalls in place with no timeout. A held even sample is kept indefinitely.
- Only whole pairs are written; the RAM never sees a half-written pair.
- Reset mid-frame:
  - Returns to IDLE and discards any held sample.
  - Drops `busy`; no `frame_done` pulse.
  - RAM contents are not touched.
- Reset values: `in_ready`=0, `wr_en_a/b`=0, `wr_addr_a/b`=0, `wr_data_a/b`=0, `busy`=0, `frame_done`=0, `bank`=0.

## Timing
- All outputs are registered.
- A pair write is issued on the cycle after the odd sample transfer. `wr_en_a` and `wr_en_b` are high together for exactly one cycle, with address and data valid in that same cycle.
- `frame_done` is coincident with the final `wr_en_a/b` cycle. `busy` falls in that same cycle.
- `in_ready` falls in the cycle after the final transfer.
- `start` accepted in cycle n gives `in_ready`=1 and `busy`=1 in cycle n+1.
- Back-to-back frames:
  - The earliest next `start` is accepted in the cycle `frame_done` is high. The writer is in IDLE then.
  - The next frame's first sample can transfer 2 cycles after the last sample of the previous frame.
- Maximum throughput: 1 sample per cycle, i.e. 1 pair write every 2 cycles.

## Configuration
- `RAM_WRITER_BANK_EN` defined:
  - Ping-pong double buffering. The address MSB is the bank bit; FRAME_LEN = 2^(ADDR_W-1).
  - The internal write bank toggles at each `frame_done`. The readers then work on `bank` while the next frame fills the other half.
  - `bank` takes the completed frame's bank bit in the `frame_done` cycle.
  - Reset sets the write bank to 0.
- Not defined:
  - Single buffer; FRAME_LEN = 2^ADDR_W and every frame overwrites the whole RAM.
  - `bank` is constant 0.

## Structure
- Shared package `radar_ram_pkg` holds:
  - constants `RAM_ADDR_W`=11 and `RAM_DATA_W`=8 (parameter defaults reference these);
  - the writer state enum (IDLE, EVEN, ODD).
- Single module, no sub-modules. The pair counter, hold register and FSM fit comfortably in one block.

## Test plan
- Reset, then `start`, then 2048 continuous samples with value = index mod 256 (no banking) → 1024 paired writes with A=2k/data 2k mod 256 and B=2k+1. `frame_done` pulses once, with the write at A=2046/B=2047.
- `in_valid` toggled pseudo-randomly with a 30% duty → identical RAM image to the first test, `wr_en_a`≡`wr_en_b` every cycle, no write before both samples of a pair have arrived.
- `start` pulsed at sample 100 mid-frame → ignored: addresses continue monotonically, exactly one `frame_done`.
- `rst_n` asserted after 7 samples (odd count) → outputs return to reset values immediately, no `frame_done`. A fresh `start` then writes the first pair to A=0/B=1.
- With `RAM_WRITER_BANK_EN`, two back-to-back frames of 1024 samples →
  - frame 1 writes addresses 0–1023 and `frame_done` shows `bank`=0;
  - frame 2 writes 1024–2047 and `frame_done` shows `bank`=1;
  - the next `start` is accepted in the `frame_done` cycle.
- `in_valid` high in IDLE with no `start` for 50 cycles → `in_ready`=0, no writes, `busy`=0.
